// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_hold_arbiter
//  Purpose  : Round-robin arbiter with grant locking and forced rotation
//             after MAX_HOLD cycles of contention.
//  Revision : 1.0  initial release
// ============================================================================
module rr_hold_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDW      = $clog2(NUM_REQ),
   localparam int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic               arb_clk,
   input  logic               arb_rst_n,
   input  logic [NUM_REQ-1:0] arb_req,
   output logic [NUM_REQ-1:0] arb_gnt,
   output logic [IDW-1:0]     arb_gnt_id,
   output logic               arb_busy,
   output logic               arb_preempt,
   output logic [CW-1:0]      arb_hold_cnt
);

   localparam logic [0:0]    S_IDLE     = 1'b0;
   localparam logic [0:0]    S_GRANT    = 1'b1;
   localparam logic [CW-1:0] c_MAX_HOLD = CW'(MAX_HOLD);
   localparam logic [IDW-1:0] c_LAST_RST = IDW'(NUM_REQ - 1);

   logic [0:0]         state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [CW-1:0]      hold_q, hold_d;
   logic               preempt_q, preempt_d;

   logic [NUM_REQ-1:0] w_owner_bit;
   logic [NUM_REQ-1:0] w_others;

   // First set bit of vec scanning ptr+1, ptr+2, ... with wrap to index 0.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                               input logic [IDW-1:0]     ptr);
      logic [IDW-1:0] pick;
      logic [IDW-1:0] sel;
      logic           found;
      int             idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         sel = IDW'(idx);
         if (!found && vec[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign w_owner_bit = NUM_REQ'(1) << owner_q;
   assign w_others    = arb_req & ~w_owner_bit;

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         last_q    <= c_LAST_RST;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            hold_d = '0;
            if (|arb_req) begin
               owner_d = rr_pick(arb_req, last_q);
               last_d  = owner_d;
               hold_d  = CW'(1);
               state_d = S_GRANT;
            end
         end
         default: begin
            if (!arb_req[owner_q]) begin
               if (|w_others) begin
                  owner_d = rr_pick(w_others, last_q);
                  last_d  = owner_d;
                  hold_d  = CW'(1);
               end else begin
                  hold_d  = '0;
                  state_d = S_IDLE;
               end
            end else if ((hold_q == c_MAX_HOLD) && (|w_others)) begin
               owner_d   = rr_pick(w_others, last_q);
               last_d    = owner_d;
               hold_d    = CW'(1);
               preempt_d = 1'b1;
            end else if (hold_q != c_MAX_HOLD) begin
               hold_d = hold_q + CW'(1);
            end
         end
      endcase
   end

   always_comb begin
      arb_gnt    = '0;
      arb_gnt_id = '0;
      if (state_q == S_GRANT) begin
         arb_gnt    = w_owner_bit;
         arb_gnt_id = owner_q;
      end
      arb_busy     = (state_q == S_GRANT);
      arb_preempt  = preempt_q;
      arb_hold_cnt = hold_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_hold_arbiter
//  Purpose  : Directed self-checking bench for rr_hold_arbiter (4 req, hold 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_hold_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int MAX_HOLD = 4;

   logic         arb_clk;
   logic         arb_rst_n;
   logic [3:0]   arb_req;
   logic [3:0]   arb_gnt;
   logic [1:0]   arb_gnt_id;
   logic         arb_busy;
   logic         arb_preempt;
   logic [2:0]   arb_hold_cnt;

   int n_pass  = 0;
   int n_total = 0;

   rr_hold_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) u_dut (
      .arb_clk      (arb_clk),
      .arb_rst_n    (arb_rst_n),
      .arb_req      (arb_req),
      .arb_gnt      (arb_gnt),
      .arb_gnt_id   (arb_gnt_id),
      .arb_busy     (arb_busy),
      .arb_preempt  (arb_preempt),
      .arb_hold_cnt (arb_hold_cnt)
   );

   initial arb_clk = 1'b0;
   always #5 arb_clk = ~arb_clk;

   // Observed bundle layout: {gnt[3:0], id[1:0], busy, preempt, hold[2:0]}
   wire [10:0] w_obs = {arb_gnt, arb_gnt_id, arb_busy, arb_preempt, arb_hold_cnt};

   function automatic logic [10:0] exp_of(input logic [3:0] g, input logic [1:0] id,
                                          input logic pre, input logic [2:0] h);
      return {g, id, |g, pre, h};
   endfunction

   task automatic tick();
      @(posedge arb_clk);
      #1;
   endtask

   task automatic test_reset();
      arb_rst_n = 1'b0;
      arb_req   = 4'b0000;
      tick();
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0000, 2'd0, 1'b0, 3'd0))
         $display("FAIL reset: got %b want %b", w_obs, exp_of(4'b0000, 2'd0, 1'b0, 3'd0));
      else n_pass++;
      @(negedge arb_clk);
      arb_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_contention();
      logic [10:0] e;
      int          own;
      arb_req = 4'b1111;
      for (int c = 0; c < 17; c++) begin
         tick();
         own = (c / 4) % 4;
         e = exp_of(4'b0001 << own, 2'(own), (c % 4 == 0) && (c > 0), 3'(c % 4 + 1));
         n_total++;
         if (w_obs !== e) $display("FAIL contention c=%0d: got %b want %b", c, w_obs, e);
         else n_pass++;
      end
      arb_req = 4'b0000;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0000, 2'd0, 1'b0, 3'd0))
         $display("FAIL contention_idle: got %b want %b", w_obs, exp_of(4'b0000, 2'd0, 1'b0, 3'd0));
      else n_pass++;
   endtask

   task automatic test_lone_holder();
      logic [10:0] e;
      arb_req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         tick();
         e = exp_of(4'b0100, 2'd2, 1'b0, (c < 3) ? 3'(c + 1) : 3'd4);
         n_total++;
         if (w_obs !== e) $display("FAIL lone_holder c=%0d: got %b want %b", c, w_obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_all_drop();
      arb_req = 4'b0000;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0000, 2'd0, 1'b0, 3'd0))
         $display("FAIL all_drop: got %b want %b", w_obs, exp_of(4'b0000, 2'd0, 1'b0, 3'd0));
      else n_pass++;
   endtask

   task automatic test_release();
      // last pointer is 2 here, so the search order is 3,0,1
      arb_req = 4'b0011;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0001, 2'd0, 1'b0, 3'd1))
         $display("FAIL release_g0: got %b want %b", w_obs, exp_of(4'b0001, 2'd0, 1'b0, 3'd1));
      else n_pass++;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0001, 2'd0, 1'b0, 3'd2))
         $display("FAIL release_hold: got %b want %b", w_obs, exp_of(4'b0001, 2'd0, 1'b0, 3'd2));
      else n_pass++;
      arb_req = 4'b0010;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0010, 2'd1, 1'b0, 3'd1))
         $display("FAIL release_handover: got %b want %b", w_obs, exp_of(4'b0010, 2'd1, 1'b0, 3'd1));
      else n_pass++;
      arb_req = 4'b0000;
      tick();
   endtask

   task automatic test_pointer();
      logic [10:0] e;
      arb_req = 4'b0100;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0100, 2'd2, 1'b0, 3'd1))
         $display("FAIL pointer_g2: got %b want %b", w_obs, exp_of(4'b0100, 2'd2, 1'b0, 3'd1));
      else n_pass++;
      arb_req = 4'b0101;
      // owner 2 expires -> 0 (wrap through 3), then owner 0 expires -> 2
      for (int c = 0; c < 7; c++) begin
         tick();
         if (c < 3)      e = exp_of(4'b0100, 2'd2, 1'b0, 3'(c + 2));
         else if (c < 6) e = exp_of(4'b0001, 2'd0, c == 3, 3'(c - 2));
         else            e = exp_of(4'b0001, 2'd0, 1'b0, 3'd4);
         n_total++;
         if (w_obs !== e) $display("FAIL pointer c=%0d: got %b want %b", c, w_obs, e);
         else n_pass++;
      end
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0100, 2'd2, 1'b1, 3'd1))
         $display("FAIL pointer_back_to_2: got %b want %b", w_obs, exp_of(4'b0100, 2'd2, 1'b1, 3'd1));
      else n_pass++;
      arb_req = 4'b0001;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0001, 2'd0, 1'b0, 3'd1))
         $display("FAIL pointer_release_to_0: got %b want %b", w_obs, exp_of(4'b0001, 2'd0, 1'b0, 3'd1));
      else n_pass++;
      arb_req = 4'b0000;
      tick();
   endtask

   task automatic test_glitch();
      // a pulse that never spans an edge must not be granted
      arb_req = 4'b0010;
      #3;
      arb_req = 4'b0000;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0000, 2'd0, 1'b0, 3'd0))
         $display("FAIL glitch: got %b want %b", w_obs, exp_of(4'b0000, 2'd0, 1'b0, 3'd0));
      else n_pass++;
   endtask

   task automatic test_reset_mid_grant();
      // last pointer is 0 here, so 1000 alone goes to requester 3
      arb_req = 4'b1000;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b1000, 2'd3, 1'b0, 3'd1))
         $display("FAIL midrst_g3: got %b want %b", w_obs, exp_of(4'b1000, 2'd3, 1'b0, 3'd1));
      else n_pass++;
      #2;
      arb_rst_n = 1'b0;
      #1;
      n_total++;
      if (w_obs !== exp_of(4'b0000, 2'd0, 1'b0, 3'd0))
         $display("FAIL midrst_async: got %b want %b", w_obs, exp_of(4'b0000, 2'd0, 1'b0, 3'd0));
      else n_pass++;
      arb_req = 4'b1111;
      @(negedge arb_clk);
      arb_rst_n = 1'b1;
      tick();
      n_total++;
      if (w_obs !== exp_of(4'b0001, 2'd0, 1'b0, 3'd1))
         $display("FAIL midrst_first_g0: got %b want %b", w_obs, exp_of(4'b0001, 2'd0, 1'b0, 3'd1));
      else n_pass++;
      arb_req = 4'b0000;
      tick();
   endtask

   initial begin
      arb_rst_n = 1'b0;
      arb_req   = 4'b0000;
      test_reset();
      test_contention();
      test_lone_holder();
      test_all_drop();
      test_release();
      test_pointer();
      test_glitch();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1);
   end

endmodule
`default_nettype wire
